// File: rtl/multi_lane_lpe_node.sv
// Multi-lane systolic MAC node: LANES psums updated per beat from a shared weight.
// Optional LPE_SATURATE_EN clamps each lane sum and adds the sticky err_saturated output.
module multi_lane_lpe_node #(
    parameter int PE_NUMBER_I         = 4,
    parameter int PE_NUMBER_J         = 4,
    parameter int PE_POSITION_I       = 0,
    parameter int PE_POSITION_J       = 0,
    parameter int LANES               = 2,
    parameter int OP0_WIDTH           = 16,
    parameter int OP0_FRACTIONAL_BITS = 12,
    parameter int IS_UNSIGNED_OP0     = 0,
    parameter int OP1_WIDTH           = 16,
    parameter int OP1_FRACTIONAL_BITS = 12,
    parameter int IS_UNSIGNED_OP1     = 0,
    parameter int PSUM_WIDTH          = OP0_WIDTH + OP1_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LANES*OP0_WIDTH-1:0]    s_axis_l_tdata,
    input  logic                          s_axis_l_tvalid,
    output logic                          s_axis_l_tready,
    input  logic                          s_axis_l_tlast,
    output logic [LANES*OP0_WIDTH-1:0]    m_axis_r_tdata,
    output logic                          m_axis_r_tvalid,
    input  logic                          m_axis_r_tready,
    output logic                          m_axis_r_tlast,
    input  logic [OP1_WIDTH-1:0]          s_axis_t_tdata,
    input  logic                          s_axis_t_tvalid,
    output logic                          s_axis_t_tready,
    input  logic                          s_axis_t_tlast,
    output logic [OP1_WIDTH-1:0]          m_axis_b_tdata,
    output logic                          m_axis_b_tvalid,
    input  logic                          m_axis_b_tready,
    output logic                          m_axis_b_tlast,
    input  logic [LANES*PSUM_WIDTH-1:0]   s_axis_u_tdata,
    input  logic                          s_axis_u_tvalid,
    output logic                          s_axis_u_tready,
    input  logic                          s_axis_u_tlast,
    output logic [LANES*PSUM_WIDTH-1:0]   m_axis_d_tdata,
    output logic                          m_axis_d_tvalid,
    input  logic                          m_axis_d_tready,
    output logic                          m_axis_d_tlast,
    output logic                          err_unaligned_data,
    output logic [15:0]                   beat_count
`ifdef LPE_SATURATE_EN
    ,
    output logic                          err_saturated
`endif
);

    localparam bit HAS_U       = (PE_POSITION_J != 0);
    localparam bit HAS_R       = (PE_POSITION_I != PE_NUMBER_I - 1);
    localparam bit HAS_B       = (PE_POSITION_J != PE_NUMBER_J - 1);
    localparam int PROD_W      = OP0_WIDTH + OP1_WIDTH;
    localparam int EXT_W       = (PROD_W > PSUM_WIDTH) ? PROD_W : PSUM_WIDTH;
    localparam bit PROD_SIGNED = !((IS_UNSIGNED_OP0 != 0) && (IS_UNSIGNED_OP1 != 0));
    localparam int LW          = LANES * OP0_WIDTH;
    localparam int DW          = LANES * PSUM_WIDTH;

    logic [LW-1:0]        r_data_q, r_data_d;
    logic                 r_valid_q, r_valid_d, r_last_q, r_last_d;
    logic [OP1_WIDTH-1:0] b_data_q, b_data_d;
    logic                 b_valid_q, b_valid_d, b_last_q, b_last_d;
    logic [DW-1:0]        d_data_q, d_data_d;
    logic                 d_valid_q, d_valid_d, d_last_q, d_last_d;
    logic                 err_q, err_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [DW-1:0]        sum_data;
    logic                 r_ok, b_ok, d_ok, stages_ok, u_term, fire;
`ifdef LPE_SATURATE_EN
    logic                 sat_q, sat_d, sat_hit;
`endif

    // Absent edge stages never block, so an edge node streams regardless of their readies.
    assign r_ok      = !HAS_R || !r_valid_q || m_axis_r_tready;
    assign b_ok      = !HAS_B || !b_valid_q || m_axis_b_tready;
    assign d_ok      = !d_valid_q || m_axis_d_tready;
    assign stages_ok = r_ok && b_ok && d_ok;
    assign u_term    = s_axis_u_tvalid || !HAS_U;
    assign fire      = s_axis_l_tvalid && s_axis_t_tvalid && u_term && stages_ok;

    assign s_axis_l_tready = s_axis_t_tvalid && u_term && stages_ok;
    assign s_axis_t_tready = s_axis_l_tvalid && u_term && stages_ok;
    assign s_axis_u_tready = HAS_U ? (s_axis_l_tvalid && s_axis_t_tvalid && stages_ok) : 1'b1;

    always_comb begin : lane_math
        logic [OP0_WIDTH-1:0]  op0;
        logic [PROD_W-1:0]     op0_x, op1_x, prod;
        logic [EXT_W-1:0]      prod_ext;
        logic [PSUM_WIDTH-1:0] addend, psum_in;
`ifdef LPE_SATURATE_EN
        logic [PSUM_WIDTH:0]   wide;
`endif
        sum_data = '0;
        op0      = '0;
        op0_x    = '0;
        op1_x    = '0;
        prod     = '0;
        prod_ext = '0;
        addend   = '0;
        psum_in  = '0;
`ifdef LPE_SATURATE_EN
        sat_hit  = 1'b0;
        wide     = '0;
`endif
        for (int unsigned k = 0; k < LANES; k++) begin
            op0   = s_axis_l_tdata[k*OP0_WIDTH +: OP0_WIDTH];
            op0_x = (IS_UNSIGNED_OP0 != 0) ? {{OP1_WIDTH{1'b0}}, op0}
                                           : {{OP1_WIDTH{op0[OP0_WIDTH-1]}}, op0};
            op1_x = (IS_UNSIGNED_OP1 != 0) ? {{OP0_WIDTH{1'b0}}, s_axis_t_tdata}
                                           : {{OP0_WIDTH{s_axis_t_tdata[OP1_WIDTH-1]}}, s_axis_t_tdata};
            // Low PROD_W bits of the product are the same for signed and unsigned operands.
            prod     = op0_x * op1_x;
            prod_ext = PROD_SIGNED ? EXT_W'($signed(prod)) : EXT_W'(prod);
            addend   = prod_ext[PSUM_WIDTH-1:0];
            psum_in  = HAS_U ? s_axis_u_tdata[k*PSUM_WIDTH +: PSUM_WIDTH] : '0;
`ifdef LPE_SATURATE_EN
            wide = {psum_in[PSUM_WIDTH-1], psum_in} + {addend[PSUM_WIDTH-1], addend};
            if (wide[PSUM_WIDTH] != wide[PSUM_WIDTH-1]) begin
                sat_hit = 1'b1;
                sum_data[k*PSUM_WIDTH +: PSUM_WIDTH] = wide[PSUM_WIDTH]
                    ? {1'b1, {(PSUM_WIDTH-1){1'b0}}} : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
            end else begin
                sum_data[k*PSUM_WIDTH +: PSUM_WIDTH] = wide[PSUM_WIDTH-1:0];
            end
`else
            sum_data[k*PSUM_WIDTH +: PSUM_WIDTH] = psum_in + addend;
`endif
        end
    end

    always_comb begin
        r_data_d  = r_data_q;
        r_valid_d = r_valid_q;
        r_last_d  = r_last_q;
        b_data_d  = b_data_q;
        b_valid_d = b_valid_q;
        b_last_d  = b_last_q;
        d_data_d  = d_data_q;
        d_valid_d = d_valid_q;
        d_last_d  = d_last_q;
        if (HAS_R) begin
            if (fire) begin
                r_data_d  = s_axis_l_tdata;
                r_last_d  = s_axis_l_tlast;
                r_valid_d = 1'b1;
            end else if (m_axis_r_tready) begin
                r_valid_d = 1'b0;
            end
        end
        if (HAS_B) begin
            if (fire) begin
                b_data_d  = s_axis_t_tdata;
                b_last_d  = s_axis_t_tlast;
                b_valid_d = 1'b1;
            end else if (m_axis_b_tready) begin
                b_valid_d = 1'b0;
            end
        end
        if (fire) begin
            d_data_d  = sum_data;
            d_last_d  = s_axis_l_tlast;
            d_valid_d = 1'b1;
        end else if (m_axis_d_tready) begin
            d_valid_d = 1'b0;
        end
        err_d = err_q || (fire && ((s_axis_l_tlast != s_axis_t_tlast) ||
                                   (HAS_U && (s_axis_u_tlast != s_axis_l_tlast))));
        cnt_d = fire ? cnt_q + 16'd1 : cnt_q;
`ifdef LPE_SATURATE_EN
        sat_d = sat_q || (fire && sat_hit);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            b_data_q  <= '0;
            b_valid_q <= 1'b0;
            b_last_q  <= 1'b0;
            d_data_q  <= '0;
            d_valid_q <= 1'b0;
            d_last_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
`ifdef LPE_SATURATE_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            r_last_q  <= r_last_d;
            b_data_q  <= b_data_d;
            b_valid_q <= b_valid_d;
            b_last_q  <= b_last_d;
            d_data_q  <= d_data_d;
            d_valid_q <= d_valid_d;
            d_last_q  <= d_last_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`ifdef LPE_SATURATE_EN
            sat_q     <= sat_d;
`endif
        end
    end

    assign m_axis_r_tdata     = r_data_q;
    assign m_axis_r_tvalid    = r_valid_q;
    assign m_axis_r_tlast     = r_last_q;
    assign m_axis_b_tdata     = b_data_q;
    assign m_axis_b_tvalid    = b_valid_q;
    assign m_axis_b_tlast     = b_last_q;
    assign m_axis_d_tdata     = d_data_q;
    assign m_axis_d_tvalid    = d_valid_q;
    assign m_axis_d_tlast     = d_last_q;
    assign err_unaligned_data = err_q;
    assign beat_count         = cnt_q;
`ifdef LPE_SATURATE_EN
    assign err_saturated      = sat_q;
`endif

endmodule

// File: tb/tb_multi_lane_lpe_node.sv
// Bench for multi_lane_lpe_node: interior node (g=0), first-row node (g=1), last row/column node (g=2).
// Expected sums come from integer arithmetic on the beat values; outputs are matched through FIFO scoreboards.
module tb_multi_lane_lpe_node;

    localparam int LN  = 2;
    localparam int OW  = 16;
    localparam int WW  = 16;
    localparam int PW  = 32;
    localparam int LDW = LN * OW;
    localparam int DDW = LN * PW;
    localparam longint PMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint PMIN = -64'sh0000_0000_8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [LDW-1:0] l_data[3], r_data[3];
    logic [WW-1:0]  t_data[3], b_data[3];
    logic [DDW-1:0] u_data[3], d_data[3];
    logic l_valid[3], l_ready[3], l_last[3], r_valid[3], r_ready[3], r_last[3];
    logic t_valid[3], t_ready[3], t_last[3], b_valid[3], b_ready[3], b_last[3];
    logic u_valid[3], u_ready[3], u_last[3], d_valid[3], d_ready[3], d_last[3];
    logic err_ua[3];
    logic [15:0] bc[3];
`ifdef LPE_SATURATE_EN
    logic err_sat[3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multi_lane_lpe_node #(
            .PE_NUMBER_I  (4),
            .PE_NUMBER_J  (4),
            .PE_POSITION_I((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .PE_POSITION_J((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .LANES        (LN)
        ) u_dut (
            .clk               (clk),
            .rst_n             (rst_n),
            .s_axis_l_tdata    (l_data[g]),
            .s_axis_l_tvalid   (l_valid[g]),
            .s_axis_l_tready   (l_ready[g]),
            .s_axis_l_tlast    (l_last[g]),
            .m_axis_r_tdata    (r_data[g]),
            .m_axis_r_tvalid   (r_valid[g]),
            .m_axis_r_tready   (r_ready[g]),
            .m_axis_r_tlast    (r_last[g]),
            .s_axis_t_tdata    (t_data[g]),
            .s_axis_t_tvalid   (t_valid[g]),
            .s_axis_t_tready   (t_ready[g]),
            .s_axis_t_tlast    (t_last[g]),
            .m_axis_b_tdata    (b_data[g]),
            .m_axis_b_tvalid   (b_valid[g]),
            .m_axis_b_tready   (b_ready[g]),
            .m_axis_b_tlast    (b_last[g]),
            .s_axis_u_tdata    (u_data[g]),
            .s_axis_u_tvalid   (u_valid[g]),
            .s_axis_u_tready   (u_ready[g]),
            .s_axis_u_tlast    (u_last[g]),
            .m_axis_d_tdata    (d_data[g]),
            .m_axis_d_tvalid   (d_valid[g]),
            .m_axis_d_tready   (d_ready[g]),
            .m_axis_d_tlast    (d_last[g]),
            .err_unaligned_data(err_ua[g]),
            .beat_count        (bc[g])
`ifdef LPE_SATURATE_EN
            ,
            .err_saturated     (err_sat[g])
`endif
        );
    end

    int checks = 0;
    int errors = 0;

    logic [DDW:0] qd[3][$];
    logic [LDW:0] qr[3][$];
    logic [WW:0]  qb[3][$];
    logic [15:0]  bc_exp[3];
    logic         err_exp[3];
    logic         sat_exp[3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One lane: psum + a*w as real integers, then wrap to 32 bits or clamp.
    function automatic logic [PW-1:0] mac(input logic [OW-1:0] a, input logic [WW-1:0] w,
                                          input logic [PW-1:0] u, output logic sat);
        longint s;
        logic [63:0] bits;
        s = longint'($signed(u)) + longint'($signed(a)) * longint'($signed(w));
        sat = 1'b0;
`ifdef LPE_SATURATE_EN
        if (s > PMAX) begin s = PMAX; sat = 1'b1; end
        else if (s < PMIN) begin s = PMIN; sat = 1'b1; end
`endif
        bits = s;
        return bits[PW-1:0];
    endfunction

    function automatic logic [DDW-1:0] expect_d(input int g, input logic [LDW-1:0] l,
                                                input logic [WW-1:0] t, input logic [DDW-1:0] u,
                                                output logic sat);
        logic [DDW-1:0] d;
        logic s1;
        d = '0;
        sat = 1'b0;
        for (int k = 0; k < LN; k++) begin
            d[k*PW +: PW] = mac(l[k*OW +: OW], t, (g == 1) ? '0 : u[k*PW +: PW], s1);
            sat |= s1;
        end
        return d;
    endfunction

    task automatic idle_all();
        for (int g = 0; g < 3; g++) begin
            l_data[g] = '0; t_data[g] = '0; u_data[g] = '0;
            l_valid[g] = 0; t_valid[g] = 0; u_valid[g] = 0;
            l_last[g] = 0; t_last[g] = 0; u_last[g] = 0;
            r_ready[g] = 1; b_ready[g] = 1; d_ready[g] = 1;
        end
    endtask

    task automatic clear_model();
        for (int g = 0; g < 3; g++) begin
            qd[g].delete(); qr[g].delete(); qb[g].delete();
            bc_exp[g] = '0; err_exp[g] = 0; sat_exp[g] = 0;
        end
    endtask

    task automatic stream(input int g, input int n, input int vpct, input int rpct,
                          input int bad_at, output int ncyc);
        logic [LDW-1:0] l;
        logic [WW-1:0]  t;
        logic [DDW-1:0] u, dexp;
        logic [DDW:0]   ed;
        logic [LDW:0]   er;
        logic [WW:0]    eb;
        logic have, lv, tv, uv, lastv, fire, sat;
        int sent, cyc;
        sent = 0; cyc = 0; have = 0; lv = 0; tv = 0; uv = 0; ncyc = 0;
        l = '0; t = '0; u = '0;
        while ((sent < n || qd[g].size() != 0 || qr[g].size() != 0 || qb[g].size() != 0)
               && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (!have && sent < n) begin
                l = $urandom();
                t = WW'($urandom());
                u = {$urandom(), $urandom()};
                lastv = (sent % 4 == 3);
                l_data[g] = l; t_data[g] = t; u_data[g] = u;
                l_last[g] = lastv;
                t_last[g] = (sent == bad_at) ? !lastv : lastv;
                u_last[g] = lastv;
                have = 1;
            end
            if (have) begin
                if ($urandom_range(0, 99) < vpct) lv = 1;
                if ($urandom_range(0, 99) < vpct) tv = 1;
                if ($urandom_range(0, 99) < vpct && g != 1) uv = 1;
            end
            l_valid[g] = lv; t_valid[g] = tv; u_valid[g] = uv;
            d_ready[g] = ($urandom_range(0, 99) < rpct);
            r_ready[g] = (g == 2) ? 1'b0 : ($urandom_range(0, 99) < rpct);
            b_ready[g] = (g == 2) ? 1'b0 : ($urandom_range(0, 99) < rpct);
            #1;
            chk("beat_count", bc[g], bc_exp[g]);
            chk("err_unaligned", err_ua[g], err_exp[g]);
`ifdef LPE_SATURATE_EN
            chk("err_saturated", err_sat[g], sat_exp[g]);
`endif
            if (g == 2) begin
                chk("edge_r_valid", r_valid[g], 0);
                chk("edge_b_valid", b_valid[g], 0);
            end
            if (g == 1) chk("edge_u_ready", u_ready[g], 1);
            if (d_valid[g] && d_ready[g]) begin
                if (qd[g].size() == 0) chk("d_spurious", 1, 0);
                else begin
                    ed = qd[g].pop_front();
                    chk("d_data", d_data[g], ed[DDW-1:0]);
                    chk("d_last", d_last[g], ed[DDW]);
                end
            end
            if (r_valid[g] && r_ready[g]) begin
                if (qr[g].size() == 0) chk("r_spurious", 1, 0);
                else begin
                    er = qr[g].pop_front();
                    chk("r_data", {r_last[g], r_data[g]}, er);
                end
            end
            if (b_valid[g] && b_ready[g]) begin
                if (qb[g].size() == 0) chk("b_spurious", 1, 0);
                else begin
                    eb = qb[g].pop_front();
                    chk("b_data", {b_last[g], b_data[g]}, eb);
                end
            end
            fire = lv && l_ready[g];
            chk("join_t", tv && t_ready[g], fire);
            if (g != 1) chk("join_u", uv && u_ready[g], fire);
            chk("fire_needs_valids", fire && !(tv && (uv || g == 1)), 0);
            if (fire) begin
                dexp = expect_d(g, l, t, u, sat);
                qd[g].push_back({l_last[g], dexp});
                if (g != 2) begin
                    qr[g].push_back({l_last[g], l});
                    qb[g].push_back({t_last[g], t});
                end
                bc_exp[g] = bc_exp[g] + 16'd1;
                if (l_last[g] != t_last[g] || (g != 1 && u_last[g] != l_last[g])) err_exp[g] = 1;
                sat_exp[g] |= sat;
                sent++;
                have = 0; lv = 0; tv = 0; uv = 0;
                if (sent == n) ncyc = cyc;
            end
        end
        if (cyc >= 4000) chk("stream_timeout", 1, 0);
        l_valid[g] = 0; t_valid[g] = 0; u_valid[g] = 0;
    endtask

    initial begin
        logic [LDW-1:0] la, lb;
        logic [WW-1:0]  ta, tb;
        logic [DDW-1:0] ua, ub, ea, eb2;
        logic s;
        int nc;

        idle_all();
        clear_model();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst_d_valid", d_valid[g], 0);
            chk("rst_r_valid", r_valid[g], 0);
            chk("rst_b_valid", b_valid[g], 0);
            chk("rst_d_data", d_data[g], 0);
            chk("rst_r_data", r_data[g], 0);
            chk("rst_b_data", b_data[g], 0);
            chk("rst_lasts", {d_last[g], r_last[g], b_last[g]}, 0);
            chk("rst_err", err_ua[g], 0);
            chk("rst_beat_count", bc[g], 0);
        end

        // Interior node, single beat, all downstream ready
        @(negedge clk);
        l_data[0] = {16'h2000, 16'h1000}; t_data[0] = 16'h0800;
        u_data[0] = {32'h0100_0000, 32'h0000_0000};
        l_valid[0] = 1; t_valid[0] = 1; u_valid[0] = 1;
        #1 chk("t1_l_ready", l_ready[0], 1);
        @(negedge clk);
        l_valid[0] = 0; t_valid[0] = 0; u_valid[0] = 0;
        #1;
        chk("t1_d_data", d_data[0], 64'h0200_0000_0080_0000);
        chk("t1_d_valid", d_valid[0], 1);
        chk("t1_r_data", {r_valid[0], r_data[0]}, {1'b1, 32'h2000_1000});
        chk("t1_b_data", {b_valid[0], b_data[0]}, {1'b1, 16'h0800});
        chk("t1_beat_count", bc[0], 1);
        @(negedge clk);
        #1 chk("t1_d_drained", d_valid[0], 0);

        // Backpressure: d_ready low for 5 cycles with inputs valid throughout
        la = $urandom(); ta = WW'($urandom()); ua = {$urandom(), $urandom()};
        lb = $urandom(); tb = WW'($urandom()); ub = {$urandom(), $urandom()};
        ea = expect_d(0, la, ta, ua, s);
        sat_exp[0] |= s;
        eb2 = expect_d(0, lb, tb, ub, s);
        sat_exp[0] |= s;
        @(negedge clk);
        l_data[0] = la; t_data[0] = ta; u_data[0] = ua;
        l_valid[0] = 1; t_valid[0] = 1; u_valid[0] = 1; d_ready[0] = 0;
        #1 chk("bp_first_ready", l_ready[0], 1);
        @(negedge clk);
        l_data[0] = lb; t_data[0] = tb; u_data[0] = ub;
        #1;
        chk("bp_hold_data", d_data[0], ea);
        chk("bp_l_ready", l_ready[0], 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_data", d_data[0], ea);
            chk("bp_hold_valid", d_valid[0], 1);
            chk("bp_ready_all", {l_ready[0], t_ready[0], u_ready[0]}, 0);
            chk("bp_beat_count", bc[0], 2);
        end
        @(negedge clk);
        d_ready[0] = 1;
        #1;
        chk("bp_release_data", d_data[0], ea);
        chk("bp_release_ready", l_ready[0], 1);
        @(negedge clk);
        l_valid[0] = 0; t_valid[0] = 0; u_valid[0] = 0;
        #1;
        chk("bp_second_beat", d_data[0], eb2);
        chk("bp_beat_count", bc[0], 3);
        @(negedge clk);
        #1 chk("bp_drained", d_valid[0], 0);
        bc_exp[0] = 16'd3;

        // Saturation corner: u = max positive, l = t = 0x7FFF
        @(negedge clk);
        l_data[0] = {16'h7FFF, 16'h7FFF}; t_data[0] = 16'h7FFF;
        u_data[0] = {32'h7FFF_FFFF, 32'h7FFF_FFFF};
        l_valid[0] = 1; t_valid[0] = 1; u_valid[0] = 1;
        @(negedge clk);
        l_valid[0] = 0; t_valid[0] = 0; u_valid[0] = 0;
        #1;
`ifdef LPE_SATURATE_EN
        chk("sat_d_data", d_data[0], 64'h7FFF_FFFF_7FFF_FFFF);
        chk("sat_flag", err_sat[0], 1);
        sat_exp[0] = 1;
`else
        chk("wrap_d_data", d_data[0], 64'hBFFF_0000_BFFF_0000);
`endif
        bc_exp[0] = 16'd4;
        @(negedge clk);

        // First-row node: u ignored, psum_in is zero
        @(negedge clk);
        l_data[1] = {16'h1000, 16'h1000}; t_data[1] = 16'h1000;
        u_data[1] = {$urandom(), $urandom()};
        l_valid[1] = 1; t_valid[1] = 1; u_valid[1] = 0;
        #1 chk("t3_u_ready", u_ready[1], 1);
        @(negedge clk);
        l_valid[1] = 0; t_valid[1] = 0;
        #1 chk("t3_d_data", d_data[1], 64'h0100_0000_0100_0000);
        bc_exp[1] = 16'd1;
        @(negedge clk);

        // Random streams, full throughput and random back-pressure
        stream(2, 12, 100, 100, -1, nc);
        chk("t4_full_rate_cycles", nc, 12);
        stream(0, 16, 100, 100, -1, nc);
        chk("t0_full_rate_cycles", nc, 16);
        for (int g = 0; g < 3; g++) stream(g, 40, 70, 60, -1, nc);

        // tlast mismatch on beat 3 then keeps sticky
        stream(0, 8, 100, 100, 3, nc);
        chk("t5_err_set", err_ua[0], 1);
        stream(0, 10, 80, 70, -1, nc);
        chk("t5_err_sticky", err_ua[0], 1);

        // Reset in the middle of a stalled beat
        @(negedge clk);
        l_data[0] = $urandom(); t_data[0] = 16'h1234; u_data[0] = {$urandom(), $urandom()};
        l_valid[0] = 1; t_valid[0] = 1; u_valid[0] = 1; d_ready[0] = 0;
        @(negedge clk);
        #1 chk("mid_loaded", d_valid[0], 1);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_d_valid", d_valid[0], 0);
        chk("mid_rst_d_data", d_data[0], 0);
        chk("mid_rst_r_valid", r_valid[0], 0);
        chk("mid_rst_err", err_ua[0], 0);
        chk("mid_rst_beat_count", bc[0], 0);
        chk("mid_rst_beat_count_g1", bc[1], 0);
        idle_all();
        clear_model();
        @(negedge clk);
        rst_n = 1;
        #1 chk("post_rst_d_valid", d_valid[0], 0);
        stream(0, 12, 90, 80, -1, nc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
